// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD counter display: active-low segment codes
// in {a,b,c,d,e,f,g} order and the BCD-to-segment decoder.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int unsigned AN_W = 8;

  function automatic logic [6:0] seg7(input logic [3:0] i_bcd);
    case (i_bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_counter_display_digit.sv
// One registered BCD digit. Steps up or down when its carry/borrow input is
// set; carry/borrow outputs are combinational so a full chain settles in one cycle.
module bcd_digit
  import bcd_disp_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_up_dn,
  input  logic       i_carry_in,
  input  logic       i_borrow_in,
  output logic [3:0] o_digit,
  output logic       o_carry_out,
  output logic       o_borrow_out
);

  logic [3:0] r_digit;
  logic       w_at9;
  logic       w_at0;

  // Anything at or above 9 rolls to 0 so a corrupted code self-heals.
  assign w_at9 = (r_digit >= 4'd9);
  assign w_at0 = (r_digit == 4'd0);

  assign o_carry_out  = i_up_dn & i_carry_in & w_at9;
  assign o_borrow_out = ~i_up_dn & i_borrow_in & w_at0;
  assign o_digit      = r_digit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_digit <= 4'd0;
    end else if (i_clr) begin
      r_digit <= 4'd0;
    end else if (i_up_dn && i_carry_in) begin
      r_digit <= w_at9 ? 4'd0 : r_digit + 4'd1;
    end else if (!i_up_dn && i_borrow_in) begin
      r_digit <= w_at0 ? 4'd9 : r_digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_display.sv
// Prescaled multi-digit BCD up/down counter with a time-multiplexed,
// active-low 7-segment scan driver and optional leading-zero blanking.
module bcd_counter_display
  import bcd_disp_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned REFRESH_HZ  = 1000,
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic                    CLK100MHZ,
  input  logic                    RST,
  input  logic                    EN,
  input  logic                    UP_DN,
  input  logic                    CLR,
  output logic [AN_W-1:0]         AN,
  output logic [6:0]              OUT,
  output logic [4*NUM_DIGITS-1:0] COUNT,
  output logic                    WRAP
);

  localparam int unsigned TICK_DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned SCAN_RAW   = CLK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int unsigned SCAN_DIV   = (SCAN_RAW < 1) ? 1 : SCAN_RAW;
  localparam int unsigned PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCAN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PRE_W-1:0]  r_presc;
  logic [SCAN_W-1:0] r_scan_div;
  logic [IDX_W-1:0]  r_idx;
  logic              r_wrap;
  logic [AN_W-1:0]   r_an;
  logic [6:0]        r_out;

  logic              w_tick;
  logic              w_step;
  logic              w_scan_tc;
  logic              w_carry  [NUM_DIGITS+1];
  logic              w_borrow [NUM_DIGITS+1];
  logic [3:0]        w_digit  [NUM_DIGITS];
  logic [NUM_DIGITS:0] w_allz;
  logic [3:0]        w_cur;
  logic              w_blank;

  assign w_tick    = (r_presc == PRE_W'(TICK_DIV - 1));
  assign w_step    = w_tick & EN;
  assign w_scan_tc = (r_scan_div == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_presc <= '0;
    end else if (CLR || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  assign w_carry[0]  = w_step;
  assign w_borrow[0] = w_step;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .i_clk        (CLK100MHZ),
      .i_rst        (RST),
      .i_clr        (CLR),
      .i_up_dn      (UP_DN),
      .i_carry_in   (w_carry[g]),
      .i_borrow_in  (w_borrow[g]),
      .o_digit      (w_digit[g]),
      .o_carry_out  (w_carry[g+1]),
      .o_borrow_out (w_borrow[g+1])
    );
    assign COUNT[4*g +: 4] = w_digit[g];
  end

  // A carry or borrow falling off the top digit is the rollover.
  always_ff @(posedge CLK100MHZ) begin
    if (RST || CLR) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_carry[NUM_DIGITS] | w_borrow[NUM_DIGITS];
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_scan_div <= '0;
      r_idx      <= '0;
    end else if (w_scan_tc) begin
      r_scan_div <= '0;
      r_idx      <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_scan_div <= r_scan_div + SCAN_W'(1);
    end
  end

  // w_allz[i] is set when digits i..NUM_DIGITS-1 are all zero.
  always_comb begin
    w_allz = '0;
    w_allz[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_allz[i] = w_allz[i+1] & (w_digit[i] == 4'd0);
    end
  end

  always_comb begin
    w_cur   = 4'd0;
    w_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur   = w_digit[i];
        w_blank = (BLANK_LZ != 0) && (i != 0) && w_allz[i];
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_an  <= {AN_W{1'b1}};
      r_out <= SEG_BLANK;
    end else begin
      r_an  <= ~(AN_W'(1) << r_idx);
      r_out <= w_blank ? SEG_BLANK : seg7(w_cur);
    end
  end

  assign AN   = r_an;
  assign OUT  = r_out;
  assign WRAP = r_wrap;

endmodule
